// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative MULT/MULTU/DIV/DIVU, one bit per cycle (shift-add / restoring divide).
// Optional build macro MULDIV_EARLY_OUT_EN: multiply stops once the multiplier's MSB is consumed.
//   state | meaning
//   IDLE  | waiting for start; operand magnitudes and signs latched on accept
//   CALC  | one multiply/divide iteration per enabled edge
//   FIX   | apply result signs, register hi/lo, pulse done
module muldiv_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
  state_t state;

  logic [CW-1:0]      cnt;
  logic               is_div, res_neg, rem_neg;
  logic [2*WIDTH-1:0] acc;   // product, or {remainder, quotient}
  logic [2*WIDTH-1:0] opa;   // shifted multiplicand, or divisor in low half
  logic [WIDTH-1:0]   opb;   // multiplier (shifts right) or dividend (shifts left)

  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  assign a_neg = op[0] & a[WIDTH-1];
  assign b_neg = op[0] & b[WIDTH-1];
  assign a_mag = a_neg ? -a : a;
  assign b_mag = b_neg ? -b : b;

  logic [CW-1:0] start_cnt;
`ifdef MULDIV_EARLY_OUT_EN
  always_comb begin
    start_cnt = CW'(WIDTH);
    if (!op[1]) begin
      start_cnt = CW'(1);
      for (int i = 0; i < WIDTH; i++)
        if (b_mag[i]) start_cnt = CW'(i + 1);
    end
  end
`else
  assign start_cnt = CW'(WIDTH);
`endif

  // restoring-divide step; remainder never exceeds WIDTH bits after the subtract
  logic [WIDTH:0]   rem_sh, diff;
  logic             geq;
  logic [WIDTH-1:0] rem_nx;
  always_comb begin
    rem_sh = {acc[2*WIDTH-1:WIDTH], opb[WIDTH-1]};
    geq    = rem_sh >= {1'b0, opa[WIDTH-1:0]};
    diff   = rem_sh - {1'b0, opa[WIDTH-1:0]};
    rem_nx = WIDTH'(geq ? diff : rem_sh);
  end

  logic [WIDTH-1:0] quo, rem;
  assign quo = acc[WIDTH-1:0];
  assign rem = acc[2*WIDTH-1:WIDTH];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      hi      <= '0;
      lo      <= '0;
      cnt     <= '0;
      is_div  <= 1'b0;
      res_neg <= 1'b0;
      rem_neg <= 1'b0;
      acc     <= '0;
      opa     <= '0;
      opb     <= '0;
    end else if (ena) begin
      done <= 1'b0;
      if (abort) begin
        state <= IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          IDLE: if (start) begin
            is_div  <= op[1];
            res_neg <= a_neg ^ b_neg;
            rem_neg <= a_neg;
            cnt     <= start_cnt;
            acc     <= '0;
            opa     <= op[1] ? {{WIDTH{1'b0}}, b_mag} : {{WIDTH{1'b0}}, a_mag};
            opb     <= op[1] ? a_mag : b_mag;
            state   <= CALC;
            busy    <= 1'b1;
          end
          CALC: begin
            cnt <= cnt - CW'(1);
            if (is_div) begin
              acc <= {rem_nx, acc[WIDTH-2:0], geq};
              opb <= opb << 1;
            end else begin
              if (opb[0]) acc <= acc + opa;
              opa <= opa << 1;
              opb <= opb >> 1;
            end
            if (cnt == CW'(1)) state <= FIX;
          end
          FIX: begin
            if (is_div) begin
              lo <= res_neg ? -quo : quo;
              hi <= rem_neg ? -rem : rem;
            end else begin
              {hi, lo} <= res_neg ? -acc : acc;
            end
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq (WIDTH=32): directed vectors, random ops against an
// arithmetic reference model, and abort/stall/reset/back-to-back control sequences.
module tb_muldiv_seq;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n, ena, start, abort;
  logic [1:0]   op;
  logic [W-1:0] a, b;
  logic         busy, done;
  logic [W-1:0] hi, lo;

  int checks = 0;
  int errors = 0;
  logic [63:0] last_exp;

  muldiv_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .start(start), .op(op), .a(a), .b(b),
    .abort(abort), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // {hi, lo} from the arithmetic definition of each operation
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy, q, r;
    sx = o[0] ? longint'($signed(x)) : longint'({32'b0, x});
    sy = o[0] ? longint'($signed(y)) : longint'({32'b0, y});
    if (!o[1]) return 64'(sx * sy);
    if (y == 0) return {x, (o[0] && x[31]) ? 32'd1 : 32'hFFFF_FFFF};
    q = sx / sy;
    r = sx % sy;
    return {32'(r), 32'(q)};
  endfunction

  function automatic int exp_lat(input logic [1:0] o, input logic [31:0] y);
`ifdef MULDIV_EARLY_OUT_EN
    logic [31:0] mag;
    int m;
    if (!o[1]) begin
      mag = (o[0] && y[31]) ? -y : y;
      m = 0;
      for (int i = 0; i < 32; i++) if (mag[i]) m = i;
      return m + 3;
    end
`endif
    return (o[1] || !o[1]) ? W + 2 : 0;
  endfunction

  // Issues one request starting now (time = posedge+1); lat = edges until done seen, 0 if none.
  task automatic run(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                     input int stall_at, input int stall_len, input int abort_at,
                     input bit hold, input int max_edges,
                     output int lat, output logic busy_at_done, output logic busy_after_abort);
    op = o; a = x; b = y; start = 1'b1;
    lat = 0; busy_at_done = 1'bx; busy_after_abort = 1'bx;
    for (int n = 0; n < max_edges; n++) begin
      ena   = !(n >= stall_at && n < stall_at + stall_len);
      abort = (n == abort_at);
      @(posedge clk); #1;
      if (n == abort_at) busy_after_abort = busy;
      abort = 1'b0;
      ena   = 1'b1;
      if (hold) begin
        a = $urandom; b = $urandom; op = 2'($urandom_range(0, 3));
      end else begin
        start = 1'b0;
      end
      if (done) begin
        lat = n + 1;
        busy_at_done = busy;
        break;
      end
    end
    start = 1'b0;
  endtask

  task automatic op_check(input string tag, input logic [1:0] o, input logic [31:0] x,
                          input logic [31:0] y, input logic [63:0] exp);
    int lat;
    logic bd, ba;
    run(o, x, y, 1000, 0, -1, 1'b0, 80, lat, bd, ba);
    check({tag, " result"}, {hi, lo}, exp);
    check({tag, " latency"}, 64'(lat), 64'(exp_lat(o, y)));
    check({tag, " busy at done"}, 64'(bd), 64'(0));
    last_exp = exp;
  endtask

  initial begin
    int lat;
    logic bd, ba;
    logic [1:0] ro;
    logic [31:0] ra, rb;

    rst_n = 1'b0; ena = 1'b1; start = 1'b0; abort = 1'b0; op = 2'd0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset busy/done", {62'd0, busy, done}, 64'd0);
    check("reset hi/lo", {hi, lo}, 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    op_check("mult neg3x5", 2'd1, 32'hFFFF_FFFD, 32'd5, 64'hFFFF_FFFF_FFFF_FFF1);
    op_check("multu max", 2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
    op_check("multu 7x5", 2'd0, 32'd7, 32'd5, 64'd35);
    op_check("div -7/2", 2'd3, 32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD);
    op_check("div ovf", 2'd3, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000);
    op_check("divu by0", 2'd2, 32'd7, 32'd0, 64'h0000_0007_FFFF_FFFF);
    op_check("div by0 neg", 2'd3, 32'hFFFF_FFF9, 32'd0, 64'hFFFF_FFF9_0000_0001);
    op_check("mult zero", 2'd1, 32'h1234_5678, 32'd0, 64'd0);

    for (int i = 0; i < 40; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = (i % 9 == 0) ? 32'h8000_0000 : $urandom;
      case ($urandom_range(0, 3))
        0: rb = 32'd0;
        1: rb = $urandom_range(1, 15);
        2: rb = 32'hFFFF_FFFF;
        default: rb = $urandom;
      endcase
      op_check($sformatf("rand%0d op%0d", i, ro), ro, ra, rb, model(ro, ra, rb));
    end

    // abort mid-CALC: no done, hi/lo keep previous result
    run(2'd2, 32'd1000, 32'd7, 1000, 0, 10, 1'b0, 60, lat, bd, ba);
    check("abort busy falls", 64'(ba), 64'(0));
    check("abort no done", 64'(lat), 64'(0));
    check("abort hi/lo kept", {hi, lo}, last_exp);

    // abort together with start in IDLE drops the start
    run(2'd0, 32'd3, 32'd3, 1000, 0, 0, 1'b0, 40, lat, bd, ba);
    check("abort+start busy", 64'(ba), 64'(0));
    check("abort+start no done", 64'(lat), 64'(0));

    // start held (with changing operands) while busy is ignored
    run(2'd0, 32'd1234, 32'd5678, 1000, 0, -1, 1'b1, 80, lat, bd, ba);
    check("held start result", {hi, lo}, 64'd1234 * 64'd5678);
    check("held start latency", 64'(lat), 64'(exp_lat(2'd0, 32'd5678)));
    @(posedge clk); #1;
    check("held start idle after", {62'd0, busy, done}, 64'd0);
    last_exp = {hi, lo};

    // back-to-back: second start issued in the done cycle
    op_check("b2b first", 2'd3, 32'd100, 32'hFFFF_FFFD, model(2'd3, 32'd100, 32'hFFFF_FFFD));
    op_check("b2b second", 2'd2, 32'd100, 32'd3, 64'h0000_0001_0000_0021);

    // ena low for 5 cycles mid-CALC stretches latency
    run(2'd2, 32'hDEAD_BEEF, 32'd77, 10, 5, -1, 1'b0, 80, lat, bd, ba);
    check("stall latency", 64'(lat), 64'(W + 2 + 5));
    check("stall result", {hi, lo}, model(2'd2, 32'hDEAD_BEEF, 32'd77));

    // done holds while ena is low
    op_check("pre hold", 2'd1, 32'd9, 32'd9, 64'd81);
    ena = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("done held ena low", 64'(done), 64'(1));
    ena = 1'b1;
    @(posedge clk); #1;
    check("done clears", 64'(done), 64'(0));

    // synchronous reset mid-CALC clears everything
    op = 2'd0; a = 32'd55; b = 32'd66; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("midrst busy/done", {62'd0, busy, done}, 64'd0);
    check("midrst hi/lo", {hi, lo}, 64'd0);
    rst_n = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    check("midrst no late done", {62'd0, busy, done}, 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
